// File: rtl/switch_code_pkg.sv
// Shared types and helpers for the switch code capture block.
// Holds the FSM states, default sizes and the digit packing helper.
package switch_code_pkg;

  typedef enum logic {
    IDLE,
    HELD
  } state_e;

  localparam int N_SW_DEF     = 10;
  localparam int DIGIT_W_DEF  = 4;
  localparam int N_DIGITS_DEF = 4;
  localparam int DEBOUNCE_DEF = 16;
  localparam int CODE_MAX_W   = 64;

  typedef logic [CODE_MAX_W-1:0] code_vec_t;

  // Overwrite digit slot pos (width w) of code with digit.
  function automatic code_vec_t pack_digit(
    input code_vec_t code,
    input int        pos,
    input int        w,
    input code_vec_t digit
  );
    code_vec_t mask;
    mask = ((code_vec_t'(1) << w) - code_vec_t'(1)) << (pos * w);
    return (code & ~mask) | ((digit << (pos * w)) & mask);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch: 2-FF synchroniser followed by a counting debouncer.
// The level toggles after DEBOUNCE_CYCLES consecutive differing samples.
module sw_debounce
  import switch_code_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic db_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/switch_code_capture.sv
// Debounced switch bank to packed multi-digit code register.
// The first press from an all-released bank enters its lowest index.
module switch_code_capture
  import switch_code_pkg::*;
#(
  parameter int N_SW            = N_SW_DEF,
  parameter int DIGIT_W         = DIGIT_W_DEF,
  parameter int N_DIGITS        = N_DIGITS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic [N_SW-1:0]                    SW,
  input  logic                               CLR,
  output logic [N_SW-1:0]                    SW_DB,
  output logic [N_DIGITS*DIGIT_W-1:0]        CODE,
  output logic [$clog2(N_DIGITS+1)-1:0]      CODE_CNT,
  output logic                               CODE_FULL,
  output logic                               DIGIT_STB,
  output logic                               OVERFLOW
);

  localparam int CW    = N_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(N_DIGITS + 1);

  if (DIGIT_W < $clog2(N_SW) || CW > CODE_MAX_W) begin : g_bad_cfg
    $error("switch_code_capture: illegal DIGIT_W/N_DIGITS");
  end

  logic [N_SW-1:0]    db, db_prev_q, rise;
  logic [DIGIT_W-1:0] digit;
  logic               press, full;
  state_e             state_q, state_d;
  logic [CW-1:0]      code_q, code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full_q, full_d;
  logic               stb_q, stb_d;
  logic               ovf_q, ovf_d;

  for (genvar i = 0; i < N_SW; i++) begin : g_db
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i (CLK),
      .rst_ni(RST_N),
      .sw_i  (SW[i]),
      .db_o  (db[i])
    );
  end

  assign rise  = db & ~db_prev_q;
  assign press = (state_q == IDLE) && (|rise);
  assign full  = (cnt_q == CNT_W'(N_DIGITS));

  always_comb begin
    digit = '0;
    for (int i = N_SW - 1; i >= 0; i--) begin
      if (rise[i]) digit = DIGIT_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|rise) state_d = HELD;
      HELD: if (db == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear outranks a coincident press; the FSM still tracks the press.
  always_comb begin
    code_d = code_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    stb_d  = 1'b0;
    if (CLR) begin
      code_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else if (press) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        code_d = CW'(pack_digit(code_vec_t'(code_q), int'(cnt_q),
                                DIGIT_W, code_vec_t'(digit)));
        cnt_d  = cnt_q + CNT_W'(1);
        stb_d  = 1'b1;
      end
    end
    full_d = (cnt_d == CNT_W'(N_DIGITS));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      db_prev_q <= '0;
      state_q   <= IDLE;
      code_q    <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      stb_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      db_prev_q <= db;
      state_q   <= state_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      stb_q     <= stb_d;
      ovf_q     <= ovf_d;
    end
  end

  assign SW_DB     = db;
  assign CODE      = code_q;
  assign CODE_CNT  = cnt_q;
  assign CODE_FULL = full_q;
  assign DIGIT_STB = stb_q;
  assign OVERFLOW  = ovf_q;

endmodule
